// File: rtl/exu_longpwbck_arb_pkg.sv
// Shared widths and helpers for the EXU long-pipe writeback/commit arbiter.
package exu_longpwbck_arb_pkg;

    localparam int XLEN        = 32;
    localparam int FLEN        = 64;
    localparam int RFIDX_WIDTH = 5;
    localparam int PC_SIZE     = 32;
    localparam int LP_CH_LSU   = 0;

    function automatic logic [FLEN-1:0] zext_xlen(input logic [XLEN-1:0] d);
        return {{(FLEN-XLEN){1'b0}}, d};
    endfunction

endpackage

// File: rtl/exu_longpwbck_arb_chk.sv
// Simulation checker for the long-pipe arbiter selection invariants.
module exu_longpwbck_arb_chk #(
    parameter int LP_CH = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic [LP_CH-1:0] hit
);

    // OITF tags are unique, so at most one slot may match the return pointer.
    a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit));

endmodule

// File: rtl/exu_longpwbck_slot.sv
// One-entry skid slot for a single long-pipe channel; refills in the cycle it drains.
module exu_longpwbck_slot
    import exu_longpwbck_arb_pkg::*;
#(
    parameter int ITAG_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fill_valid,
    input  logic [XLEN-1:0]       fill_wdat,
    input  logic [ITAG_WIDTH-1:0] fill_itag,
    input  logic                  fill_excp,
    input  logic                  fill_ld,
    input  logic                  fill_st,
    input  logic [PC_SIZE-1:0]    fill_pc,
    input  logic                  drain,
    input  logic                  bypass_take,
    output logic                  ready,
    output logic                  vld,
    output logic [XLEN-1:0]       wdat,
    output logic [ITAG_WIDTH-1:0] itag,
    output logic                  excp,
    output logic                  ld,
    output logic                  st,
    output logic [PC_SIZE-1:0]    pc
);

    logic                  vld_r;
    logic [XLEN-1:0]       wdat_r;
    logic [ITAG_WIDTH-1:0] itag_r;
    logic                  excp_r;
    logic                  ld_r;
    logic                  st_r;
    logic [PC_SIZE-1:0]    pc_r;
    logic                  load_s;

    assign ready  = ~vld_r | drain;
    // A result that retired straight from the input is accepted but never stored.
    assign load_s = fill_valid & ready & ~bypass_take;

    // Slot storage: load on accept, clear valid on drain, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r  <= 1'b0;
            wdat_r <= '0;
            itag_r <= '0;
            excp_r <= 1'b0;
            ld_r   <= 1'b0;
            st_r   <= 1'b0;
            pc_r   <= '0;
        end else if (load_s) begin
            vld_r  <= 1'b1;
            wdat_r <= fill_wdat;
            itag_r <= fill_itag;
            excp_r <= fill_excp;
            ld_r   <= fill_ld;
            st_r   <= fill_st;
            pc_r   <= fill_pc;
        end else if (drain) begin
            vld_r  <= 1'b0;
        end else begin
            vld_r  <= vld_r;
        end
    end

    assign vld  = vld_r;
    assign wdat = wdat_r;
    assign itag = itag_r;
    assign excp = excp_r;
    assign ld   = ld_r;
    assign st   = st_r;
    assign pc   = pc_r;

endmodule

// File: rtl/exu_longpwbck_arb.sv
// Long-pipe writeback/commit arbiter: retires slot contents in OITF order.
// Optional same-cycle input bypass is enabled with EXU_LONGPWBCK_BYPASS_EN.
module exu_longpwbck_arb
    import exu_longpwbck_arb_pkg::*;
#(
    parameter int LP_CH      = 2,
    parameter int ITAG_WIDTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [LP_CH-1:0]            lp_i_valid,
    output logic [LP_CH-1:0]            lp_i_ready,
    input  logic [LP_CH*XLEN-1:0]       lp_i_wdat,
    input  logic [LP_CH*ITAG_WIDTH-1:0] lp_i_itag,
    input  logic [LP_CH-1:0]            lp_i_excp,
    input  logic [LP_CH-1:0]            lp_i_ld,
    input  logic [LP_CH-1:0]            lp_i_st,
    input  logic [LP_CH*PC_SIZE-1:0]    lp_i_pc,
    input  logic                        oitf_empty,
    input  logic [ITAG_WIDTH-1:0]       oitf_ret_ptr,
    input  logic                        oitf_ret_rdwen,
    input  logic [RFIDX_WIDTH-1:0]      oitf_ret_rdidx,
    output logic                        oitf_ret_ena,
    output logic                        longp_wbck_o_valid,
    input  logic                        longp_wbck_o_ready,
    output logic [FLEN-1:0]             longp_wbck_o_wdat,
    output logic [RFIDX_WIDTH-1:0]      longp_wbck_o_rdidx,
    output logic                        longp_excp_o_valid,
    input  logic                        longp_excp_o_ready,
    output logic                        longp_excp_o_ld,
    output logic                        longp_excp_o_st,
    output logic [PC_SIZE-1:0]          longp_excp_o_pc
);

    logic [LP_CH-1:0]      slot_vld_s;
    logic [XLEN-1:0]       slot_wdat_s [LP_CH];
    logic [ITAG_WIDTH-1:0] slot_itag_s [LP_CH];
    logic [LP_CH-1:0]      slot_excp_s;
    logic [LP_CH-1:0]      slot_ld_s;
    logic [LP_CH-1:0]      slot_st_s;
    logic [PC_SIZE-1:0]    slot_pc_s   [LP_CH];

    logic [LP_CH-1:0]      hit_s;
    logic [LP_CH-1:0]      byp_s;
    logic [LP_CH-1:0]      drain_s;
    logic [LP_CH-1:0]      take_s;
    logic                  any_hit_s;
    logic                  cand_vld_s;
    logic                  go_s;
    logic [XLEN-1:0]       sel_wdat_s;
    logic                  sel_excp_s;
    logic                  sel_ld_s;
    logic                  sel_st_s;
    logic [PC_SIZE-1:0]    sel_pc_s;

    for (genvar c = 0; c < LP_CH; c++) begin : g_slot
        exu_longpwbck_slot #(
            .ITAG_WIDTH (ITAG_WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .fill_valid  (lp_i_valid[c]),
            .fill_wdat   (lp_i_wdat[c*XLEN +: XLEN]),
            .fill_itag   (lp_i_itag[c*ITAG_WIDTH +: ITAG_WIDTH]),
            .fill_excp   (lp_i_excp[c]),
            .fill_ld     (lp_i_ld[c]),
            .fill_st     (lp_i_st[c]),
            .fill_pc     (lp_i_pc[c*PC_SIZE +: PC_SIZE]),
            .drain       (drain_s[c]),
            .bypass_take (take_s[c]),
            .ready       (lp_i_ready[c]),
            .vld         (slot_vld_s[c]),
            .wdat        (slot_wdat_s[c]),
            .itag        (slot_itag_s[c]),
            .excp        (slot_excp_s[c]),
            .ld          (slot_ld_s[c]),
            .st          (slot_st_s[c]),
            .pc          (slot_pc_s[c])
        );

        assign hit_s[c] = slot_vld_s[c] & ~oitf_empty & (slot_itag_s[c] == oitf_ret_ptr);

`ifdef EXU_LONGPWBCK_BYPASS_EN
        // A buffered hit always wins over an arriving result.
        assign byp_s[c] = lp_i_valid[c] & ~slot_vld_s[c] & ~oitf_empty & ~any_hit_s
                        & (lp_i_itag[c*ITAG_WIDTH +: ITAG_WIDTH] == oitf_ret_ptr);
`else
        assign byp_s[c] = 1'b0;
`endif
    end

    assign any_hit_s  = |hit_s;
    assign cand_vld_s = any_hit_s | (|byp_s);

    // AND-OR select of the retiring entry; hit and bypass are mutually exclusive.
    always_comb begin
        sel_wdat_s = '0;
        sel_excp_s = 1'b0;
        sel_ld_s   = 1'b0;
        sel_st_s   = 1'b0;
        sel_pc_s   = '0;
        for (int c = 0; c < LP_CH; c++) begin
            sel_wdat_s = sel_wdat_s | (slot_wdat_s[c] & {XLEN{hit_s[c]}})
                                    | (lp_i_wdat[c*XLEN +: XLEN] & {XLEN{byp_s[c]}});
            sel_excp_s = sel_excp_s | (slot_excp_s[c] & hit_s[c]) | (lp_i_excp[c] & byp_s[c]);
            sel_ld_s   = sel_ld_s   | (slot_ld_s[c] & hit_s[c])   | (lp_i_ld[c] & byp_s[c]);
            sel_st_s   = sel_st_s   | (slot_st_s[c] & hit_s[c])   | (lp_i_st[c] & byp_s[c]);
            sel_pc_s   = sel_pc_s   | (slot_pc_s[c] & {PC_SIZE{hit_s[c]}})
                                    | (lp_i_pc[c*PC_SIZE +: PC_SIZE] & {PC_SIZE{byp_s[c]}});
        end
    end

    // Entries without an rd write retire unconditionally once selected.
    assign go_s = cand_vld_s & (sel_excp_s ? longp_excp_o_ready
                                           : (oitf_ret_rdwen ? longp_wbck_o_ready : 1'b1));

    assign drain_s = hit_s & {LP_CH{go_s}};
    assign take_s  = byp_s & {LP_CH{go_s}};

    assign oitf_ret_ena       = go_s;
    assign longp_wbck_o_valid = cand_vld_s & ~sel_excp_s & oitf_ret_rdwen;
    assign longp_wbck_o_wdat  = zext_xlen(sel_wdat_s);
    assign longp_wbck_o_rdidx = oitf_ret_rdidx;
    assign longp_excp_o_valid = cand_vld_s & sel_excp_s;
    assign longp_excp_o_ld    = sel_ld_s & sel_excp_s;
    assign longp_excp_o_st    = sel_st_s & sel_excp_s;
    assign longp_excp_o_pc    = sel_pc_s & {PC_SIZE{sel_excp_s}};

    exu_longpwbck_arb_chk #(
        .LP_CH (LP_CH)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .hit   (hit_s)
    );

endmodule

// File: tb/tb_exu_longpwbck_arb.sv
// Directed-vector bench for exu_longpwbck_arb in its default (no bypass) build.
module tb_exu_longpwbck_arb;
    import exu_longpwbck_arb_pkg::*;

    localparam int LP_CH      = 2;
    localparam int ITAG_WIDTH = 2;

    logic                        clk;
    logic                        rst_n;
    logic [LP_CH-1:0]            lp_i_valid;
    logic [LP_CH-1:0]            lp_i_ready;
    logic [LP_CH*XLEN-1:0]       lp_i_wdat;
    logic [LP_CH*ITAG_WIDTH-1:0] lp_i_itag;
    logic [LP_CH-1:0]            lp_i_excp;
    logic [LP_CH-1:0]            lp_i_ld;
    logic [LP_CH-1:0]            lp_i_st;
    logic [LP_CH*PC_SIZE-1:0]    lp_i_pc;
    logic                        oitf_empty;
    logic [ITAG_WIDTH-1:0]       oitf_ret_ptr;
    logic                        oitf_ret_rdwen;
    logic [RFIDX_WIDTH-1:0]      oitf_ret_rdidx;
    logic                        oitf_ret_ena;
    logic                        longp_wbck_o_valid;
    logic                        longp_wbck_o_ready;
    logic [FLEN-1:0]             longp_wbck_o_wdat;
    logic [RFIDX_WIDTH-1:0]      longp_wbck_o_rdidx;
    logic                        longp_excp_o_valid;
    logic                        longp_excp_o_ready;
    logic                        longp_excp_o_ld;
    logic                        longp_excp_o_st;
    logic [PC_SIZE-1:0]          longp_excp_o_pc;

    int n_vec = 0;
    int n_bad = 0;

    exu_longpwbck_arb #(
        .LP_CH      (LP_CH),
        .ITAG_WIDTH (ITAG_WIDTH)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lp_i_valid         (lp_i_valid),
        .lp_i_ready         (lp_i_ready),
        .lp_i_wdat          (lp_i_wdat),
        .lp_i_itag          (lp_i_itag),
        .lp_i_excp          (lp_i_excp),
        .lp_i_ld            (lp_i_ld),
        .lp_i_st            (lp_i_st),
        .lp_i_pc            (lp_i_pc),
        .oitf_empty         (oitf_empty),
        .oitf_ret_ptr       (oitf_ret_ptr),
        .oitf_ret_rdwen     (oitf_ret_rdwen),
        .oitf_ret_rdidx     (oitf_ret_rdidx),
        .oitf_ret_ena       (oitf_ret_ena),
        .longp_wbck_o_valid (longp_wbck_o_valid),
        .longp_wbck_o_ready (longp_wbck_o_ready),
        .longp_wbck_o_wdat  (longp_wbck_o_wdat),
        .longp_wbck_o_rdidx (longp_wbck_o_rdidx),
        .longp_excp_o_valid (longp_excp_o_valid),
        .longp_excp_o_ready (longp_excp_o_ready),
        .longp_excp_o_ld    (longp_excp_o_ld),
        .longp_excp_o_st    (longp_excp_o_st),
        .longp_excp_o_pc    (longp_excp_o_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int c, input logic [31:0] wdat, input logic [1:0] itag,
                        input logic excp, input logic ld, input logic st, input logic [31:0] pc);
        lp_i_valid[c]                 = 1'b1;
        lp_i_wdat[c*XLEN +: XLEN]     = wdat;
        lp_i_itag[c*ITAG_WIDTH +: ITAG_WIDTH] = itag;
        lp_i_excp[c]                  = excp;
        lp_i_ld[c]                    = ld;
        lp_i_st[c]                    = st;
        lp_i_pc[c*PC_SIZE +: PC_SIZE] = pc;
    endtask

    task automatic idle();
        lp_i_valid = '0;
        lp_i_excp  = '0;
        lp_i_ld    = '0;
        lp_i_st    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int ret;
        int extra;
        int pulses;
        logic acc;
        logic rt;

        rst_n = 1'b0;
        lp_i_valid = '0; lp_i_wdat = '0; lp_i_itag = '0; lp_i_excp = '0;
        lp_i_ld = '0; lp_i_st = '0; lp_i_pc = '0;
        oitf_empty = 1'b0; oitf_ret_ptr = 2'd0; oitf_ret_rdwen = 1'b1;
        oitf_ret_rdidx = 5'd5; longp_wbck_o_ready = 1'b1; longp_excp_o_ready = 1'b1;

        // Reset state
        samp();
        chk("rst_ready", 64'(lp_i_ready), 64'h3);
        chk("rst_wbck_valid", 64'(longp_wbck_o_valid), 64'h0);
        chk("rst_excp_valid", 64'(longp_excp_o_valid), 64'h0);
        chk("rst_ret_ena", 64'(oitf_ret_ena), 64'h0);
        chk("rst_wdat", longp_wbck_o_wdat, 64'h0);
        tick();
        rst_n = 1'b1;

        // In-order retire with one cycle of slot latency
        oitf_ret_ptr = 2'd0;
        send(0, 32'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        samp();
        chk("t1_no_early", 64'(longp_wbck_o_valid), 64'h0);
        tick();
        idle();
        samp();
        chk("t1_valid", 64'(longp_wbck_o_valid), 64'h1);
        chk("t1_wdat", longp_wbck_o_wdat, 64'h1234);
        chk("t1_rdidx", 64'(longp_wbck_o_rdidx), 64'h5);
        chk("t1_ret_ena", 64'(oitf_ret_ena), 64'h1);
        tick();
        oitf_ret_ptr = 2'd1;
        samp();
        chk("t1_drained", 64'(oitf_ret_ena), 64'h0);
        tick();

        // Out-of-order arrival: ch1 tag 1 waits for ch0 tag 0
        oitf_ret_ptr = 2'd0;
        send(1, 32'hAAAA, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        samp();
        chk("t2_hold_ready", 64'(lp_i_ready), 64'h1);
        chk("t2_hold_ret", 64'(oitf_ret_ena), 64'h0);
        tick();
        send(0, 32'hBBBB, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0);
        samp();
        chk("t2_arrive_ready", 64'(lp_i_ready), 64'h1);
        tick();
        idle();
        samp();
        chk("t2_first_wdat", longp_wbck_o_wdat, 64'hBBBB);
        chk("t2_first_ret", 64'(oitf_ret_ena), 64'h1);
        chk("t2_first_ready1", 64'(lp_i_ready[1]), 64'h0);
        tick();
        oitf_ret_ptr = 2'd1;
        samp();
        chk("t2_second_wdat", longp_wbck_o_wdat, 64'hAAAA);
        chk("t2_second_ret", 64'(oitf_ret_ena), 64'h1);
        chk("t2_second_ready", 64'(lp_i_ready), 64'h3);
        tick();
        oitf_ret_ptr = 2'd2;
        samp();
        chk("t2_empty", 64'(oitf_ret_ena), 64'h0);
        tick();

        // Exception held against excp back-pressure
        longp_excp_o_ready = 1'b0;
        send(0, 32'h5555, 2'd2, 1'b1, 1'b1, 1'b0, 32'h80000010);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            samp();
            chk($sformatf("t3_excp_valid%0d", i), 64'(longp_excp_o_valid), 64'h1);
            chk($sformatf("t3_pc%0d", i), 64'(longp_excp_o_pc), 64'h80000010);
            chk($sformatf("t3_ld%0d", i), 64'(longp_excp_o_ld), 64'h1);
            chk($sformatf("t3_wbck%0d", i), 64'(longp_wbck_o_valid), 64'h0);
            chk($sformatf("t3_noret%0d", i), 64'(oitf_ret_ena), 64'h0);
            tick();
        end
        longp_excp_o_ready = 1'b1;
        samp();
        chk("t3_ret", 64'(oitf_ret_ena), 64'h1);
        chk("t3_st", 64'(longp_excp_o_st), 64'h0);
        tick();
        oitf_ret_ptr = 2'd3;
        samp();
        chk("t3_cleared", 64'(longp_excp_o_valid), 64'h0);
        tick();

        // No-rd retire ignores writeback back-pressure
        oitf_ret_rdwen = 1'b0;
        longp_wbck_o_ready = 1'b0;
        send(1, 32'h0077, 2'd3, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        samp();
        chk("t4_ret", 64'(oitf_ret_ena), 64'h1);
        chk("t4_wbck_valid", 64'(longp_wbck_o_valid), 64'h0);
        tick();
        oitf_ret_ptr = 2'd0;
        oitf_ret_rdwen = 1'b1;
        longp_wbck_o_ready = 1'b1;

        // Back-to-back stream with wbck_ready pattern 1,0,1
        sent = 0;
        ret = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (ret >= 3) break;
            longp_wbck_o_ready = (cyc % 3 == 1) ? 1'b0 : 1'b1;
            if (sent < 3) send(0, 32'h100 + 32'(sent), 2'(sent), 1'b0, 1'b0, 1'b0, 32'h0);
            else idle();
            samp();
            acc = lp_i_valid[0] & lp_i_ready[0];
            rt  = oitf_ret_ena;
            if (rt) chk($sformatf("t5_wdat%0d", ret), longp_wbck_o_wdat, 64'h100 + 64'(oitf_ret_ptr));
            tick();
            if (acc) sent++;
            if (rt) begin
                ret++;
                oitf_ret_ptr = oitf_ret_ptr + 2'd1;
            end
        end
        idle();
        longp_wbck_o_ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            samp();
            extra += int'(oitf_ret_ena);
            tick();
        end
        chk("t5_count", 64'(ret), 64'd3);
        chk("t5_extra", 64'(extra), 64'd0);

        // Reset with both slots full discards them silently
        oitf_ret_ptr = 2'd3;
        send(0, 32'hC0C0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h0);
        send(1, 32'hD0D0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        samp();
        chk("t6_full_ready", 64'(lp_i_ready), 64'h0);
        chk("t6_full_noret", 64'(oitf_ret_ena), 64'h0);
        tick();
        rst_n = 1'b0;
        oitf_ret_ptr = 2'd1;
        #1;
        chk("t6_rst_ready", 64'(lp_i_ready), 64'h3);
        chk("t6_rst_wbck", 64'(longp_wbck_o_valid), 64'h0);
        chk("t6_rst_excp", 64'(longp_excp_o_valid), 64'h0);
        chk("t6_rst_wdat", longp_wbck_o_wdat, 64'h0);
        pulses = int'(oitf_ret_ena);
        for (int i = 0; i < 2; i++) begin
            samp();
            pulses += int'(oitf_ret_ena);
            tick();
        end
        rst_n = 1'b1;
        samp();
        pulses += int'(oitf_ret_ena);
        chk("t6_no_pulse", 64'(pulses), 64'd0);
        chk("t6_after_wbck", 64'(longp_wbck_o_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/exu_longpwbck_arb.md
# exu_longpwbck_arb

Parametrised long-pipe writeback/commit arbiter for the EXU. Collects results from `LP_CH` long-pipe units (LSU, multi-cycle MULDIV, future FPU) through per-channel one-entry skid slots. Retires them strictly in OITF order by matching each slot's itag against the OITF return pointer. Routes each retired entry either to the regfile writeback port or to the commit exception port, and pulses the OITF retire enable.

## Interface
Parameters:
- `LP_CH`, 2, number of long-pipe channels (1..4); channel 0 = LSU.
- `ITAG_WIDTH`, 2, OITF tag width; the OITF depth is `2**ITAG_WIDTH`.
- Data widths come from the shared defines: `XLEN`, `FLEN`, `RFIDX_WIDTH`, `PC_SIZE`.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- `clk  in  1  core clock`
- `rst_n  in  1  asynchronous active-low reset`
- `lp_i_valid  in  LP_CH  per-channel result valid`
- `lp_i_ready  out  LP_CH  per-channel accept`
- `lp_i_wdat  in  LP_CH*XLEN  result data, channel c at [c*XLEN +: XLEN]`
- `lp_i_itag  in  LP_CH*ITAG_WIDTH  OITF tag of the instruction`
- `lp_i_excp  in  LP_CH  result carries an exception`
- `lp_i_ld  in  LP_CH  instruction is a load`
- `lp_i_st  in  LP_CH  instruction is a store`
- `lp_i_pc  in  LP_CH*PC_SIZE  instruction PC`
- `oitf_empty  in  1  OITF holds no entries`
- `oitf_ret_ptr  in  ITAG_WIDTH  tag of the oldest OITF entry`
- `oitf_ret_rdwen  in  1  oldest entry writes rd`
- `oitf_ret_rdidx  in  RFIDX_WIDTH  rd of the oldest entry`
- `oitf_ret_ena  out  1  retire pulse for the oldest entry`
- `longp_wbck_o_valid  out  1  writeback valid`
- `longp_wbck_o_ready  in  1  writeback accept`
- `longp_wbck_o_wdat  out  FLEN  writeback data, XLEN zero-extended`
- `longp_wbck_o_rdidx  out  RFIDX_WIDTH  equals oitf_ret_rdidx`
- `longp_excp_o_valid  out  1  exception valid`
- `longp_excp_o_ready  in  1  exception accept`
- `longp_excp_o_ld  out  1  load flag`
- `longp_excp_o_st  out  1  store flag`
- `longp_excp_o_pc  out  PC_SIZE  faulting PC`

## Operation
- **Slots.** Each channel has one slot {vld, wdat, itag, excp, ld, st, pc}.
  - Fill occurs when `lp_i_valid & lp_i_ready`.
  - `lp_i_ready[c] = ~vld[c] | drain[c]`, so fill and drain can happen in the same cycle.
- **Selection.** `hit[c] = vld[c] & ~oitf_empty & (itag[c] == oitf_ret_ptr)`.
  - Tags are unique, so hit is one-hot or zero; the selected slot is chosen by AND-OR mux.
  - More than one hit bit set is illegal and is asserted in simulation.
- **Normal retire** (selected slot, `excp=0`):
  - `longp_wbck_o_valid = oitf_ret_rdwen`.
  - `drain = oitf_ret_rdwen ? longp_wbck_o_ready : 1`.
- **Exception retire** (`excp=1`):
  - `longp_excp_o_valid = 1`, and `longp_wbck_o_valid` is forced to 0 (no regfile write).
  - `drain = longp_excp_o_ready`.
  - ld/st/pc are taken from the slot.
- `oitf_ret_ena = |drain`.
- **Reset values.** On reset every slot's vld is cleared, so all outputs are 0 and `lp_i_ready` is all-ones.
- **Reset mid-operation.** Buffered results are discarded with no retire pulse; the OITF is reset by the same `rst_n`.

## Timing
- Without bypass, a result accepted in cycle N retires no earlier than cycle N+1.
- Sustained throughput is one retire per cycle across all channels.
- A non-selected slot holds its contents and keeps `lp_i_ready[c]=0` until it is drained.
- Outputs depend only on slot registers and OITF/ready inputs; there are no combinational paths from `lp_i_*` to the outputs, except under bypass.
- The `ready` inputs may combinationally affect `lp_i_ready` and `oitf_ret_ena`.

## Configuration
- Macro: `EXU_LONGPWBCK_BYPASS_EN`.
- **Defined:** an input whose itag equals `oitf_ret_ptr`, arriving while its own slot is empty, is presented directly to the outputs in the same cycle.
  - If it retires, the slot is not written (0-cycle latency); otherwise it is captured as normal.
  - `hit` from a buffered slot has priority over the bypass.
- **Undefined:** all results pass through a slot (1-cycle minimum latency).

## Structure
- The shared `defines.v` carries `XLEN`, `FLEN`, `RFIDX_WIDTH`, `PC_SIZE`, plus a new `LP_CH_LSU`=0 channel index.
- Sub-module `exu_longpwbck_slot` holds one channel buffer (fill/drain, registers, `ready`) and is instantiated `LP_CH` times by generate loop.
- Selection, routing and the exception/writeback split live in the top module.

## Test plan
- **In-order retire:** LP_CH=2, with `oitf_ret_ptr`=0.
  - Stimulus: ch0 itag 0, wdat 0x1234, rdwen=1, rdidx 5.
  - Required: cycle N+1 shows `longp_wbck_o_valid`=1, wdat 0x1234, rdidx 5, `oitf_ret_ena`=1.
- **Out-of-order arrival:** ch1 itag 1 arrives first, ch0 itag 0 arrives 2 cycles later, with ptr=0.
  - Required: ch1 holds with `lp_i_ready[1]`=0; ch0 retires, then ch1 retires the following cycle after ptr advances.
- **Exception:** ch0 `excp`=1, ld=1, pc 0x80000010, with `longp_excp_o_ready` low for 3 cycles.
  - Required: excp valid stays held with pc 0x80000010, wbck_valid=0, no retire until ready goes high.
- **No-rd retire:** `oitf_ret_rdwen`=0 and `longp_wbck_o_ready`=0.
  - Required: the entry retires in the same cycle, with `longp_wbck_o_valid`=0.
- **Back-pressure and back-to-back:** wbck_ready toggles 1,0,1 while ch0 streams tags 0,1,2.
  - Required: no loss or duplication, `oitf_ret_ena` count = 3.
- **Reset mid-flight:** `rst_n` is asserted with both slots full.
  - Required: immediately all vld=0, outputs 0, `lp_i_ready`=2'b11, and there is no `oitf_ret_ena` pulse.
